// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the program loader.
interface prog_loader_if #(
  parameter int unsigned AW = 8
) ();

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;

  // Upstream source and RAM side: drives bytes, observes writes
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

  // Loader side: consumes bytes, drives the RAM write port
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/ADDR/LEN/data/CHK frames from a byte stream,
// writes the data bytes into program RAM, and releases the CPU from reset
// only after a frame whose checksum sums to zero.
module prog_loader #(
  parameter logic [7:0]  SYNC = 8'hA5,
  parameter int unsigned AW   = 8
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    DATA,
    CHECK,
    WRITE_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept_c;
  logic [7:0]    sum_next_c;

  // A byte moves only when both sides agree in the same cycle
  assign accept_c   = bus.in_valid & in_ready_q;
  assign sum_next_c = sum_q + bus.in_data;

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Frame parser: next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        // Anything other than the start byte is line noise and dropped
        if (accept_c && (bus.in_data == SYNC)) begin
          state_d     = GET_ADDR;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_reset_d = 1'b1;
          sum_d       = 8'h00;
        end
      end

      GET_ADDR: begin
        if (accept_c) begin
          ptr_d   = AW'(bus.in_data);
          sum_d   = sum_next_c;
          state_d = GET_LEN;
        end
      end

      GET_LEN: begin
        if (accept_c) begin
          cnt_d   = bus.in_data;
          sum_d   = sum_next_c;
          state_d = (bus.in_data == 8'h00) ? CHECK : DATA;
        end
      end

      DATA: begin
        // SYNC here is plain payload; the write strikes on the next cycle
        if (accept_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = bus.in_data;
          ptr_d      = ptr_q + AW'(1);
          cnt_d      = cnt_q - 8'd1;
          sum_d      = sum_next_c;
          state_d    = WRITE_WAIT;
        end
      end

      WRITE_WAIT: begin
        // One dead cycle per data byte while the RAM write completes
        state_d = (cnt_q == 8'h00) ? CHECK : DATA;
      end

      CHECK: begin
        if (accept_c) begin
          sum_d   = sum_next_c;
          state_d = IDLE;
          if (sum_next_c == 8'h00) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            err_d       = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and activity flags follow the state being entered
    in_ready_d = (state_d != WRITE_WAIT);
    busy_d     = (state_d != IDLE);
  end

endmodule
